// File: rtl/irq_pkg.sv
// irq_pkg: state encoding and register offsets shared by the interrupt controller files.
package irq_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, INSVC = 2'd2} state_t;
  localparam int PEND_OFS = 0;
  localparam int MASK_OFS = 4;
  localparam int STAT_OFS = 8;
  localparam int EOI_OFS  = 12;
endpackage

// File: rtl/irq_controller_if.sv
// irq_controller_if: CPU-side address/control and INTR/INTA/VECTOR handshake of the interrupt controller.
interface irq_controller_if #(parameter int BITS = 32, parameter int IDW = 3);
  logic [BITS-1:0] ADDRBUS;
  logic            WE;
  logic            INTR;
  logic            INTA;
  logic [IDW-1:0]  VECTOR;
  modport master (output ADDRBUS, WE, INTA, input INTR, VECTOR);
  modport slave  (input ADDRBUS, WE, INTA, output INTR, VECTOR);
endinterface

// File: rtl/irq_priority_enc.sv
// irq_priority_enc: combinational lowest-index-first priority encoder.
module irq_priority_enc #(parameter int NSRC = 8, parameter int IDW = $clog2(NSRC)) (
  input  logic [NSRC-1:0] i_req,
  output logic            o_valid,
  output logic [IDW-1:0]  o_id
);
  always_comb begin
    o_valid = |i_req;
    o_id = '0;
    for (int i = NSRC - 1; i >= 0; i--) if (i_req[i]) o_id = IDW'(i);
  end
endmodule

// File: rtl/irq_controller.sv
// irq_controller: memory-mapped priority interrupt controller with INTR/INTA handshake and EOI retirement.
// Define NESTED_IRQ_EN to let higher-priority sources preempt an in-service one.
module irq_controller import irq_pkg::*; #(
  parameter int              BITS = 32,
  parameter int              NSRC = 8,
  parameter int              IDW  = 3,
  parameter logic [BITS-1:0] BASE = 32'hFFFF0200
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic [NSRC-1:0] IRQ_IN,
  inout  wire  [BITS-1:0] DATABUS,
  irq_controller_if.slave bus
);
  state_t          r_state, w_state_n;
  logic [NSRC-1:0] r_s1, r_s2, r_s3, r_pend, r_mask, r_insvc;
  logic [NSRC-1:0] w_edge, w_cand, w_w1c, w_ack_clr, w_insvc_n, w_onehot;
  logic [2:0]      r_vld;
  logic            r_intr, w_intr_n, w_cval, w_eoi, w_wr_pend, w_wr_mask;
  logic            w_hit_p, w_hit_m, w_hit_s, w_hit_e;
  logic [IDW-1:0]  r_vec, w_vec_n, w_cid;
  logic [BITS-1:0] w_rdata;
  logic            w_unused;
  assign w_hit_p   = bus.ADDRBUS == BASE + BITS'(PEND_OFS);
  assign w_hit_m   = bus.ADDRBUS == BASE + BITS'(MASK_OFS);
  assign w_hit_s   = bus.ADDRBUS == BASE + BITS'(STAT_OFS);
  assign w_hit_e   = bus.ADDRBUS == BASE + BITS'(EOI_OFS);
  assign w_wr_pend = bus.WE & w_hit_p;
  assign w_wr_mask = bus.WE & w_hit_m;
  assign w_eoi     = bus.WE & w_hit_e;
  assign w_w1c     = w_wr_pend ? DATABUS[NSRC-1:0] : '0;
  assign w_rdata   = w_hit_p ? BITS'(r_pend) : w_hit_m ? BITS'(r_mask) : BITS'({r_insvc, r_state, r_vec});
  assign DATABUS   = (!bus.WE && (w_hit_p || w_hit_m || w_hit_s)) ? w_rdata : 'z;
  assign w_unused  = &{1'b0, DATABUS};
  // Edges are suppressed until the sync pipeline holds real samples, so lines high at reset release do not fire.
  assign w_edge    = r_s2 & ~r_s3 & {NSRC{r_vld[2]}};
  assign w_cand    = r_pend & r_mask;
  assign w_onehot  = NSRC'(1) << w_cid;
  assign bus.INTR   = r_intr;
  assign bus.VECTOR = r_vec;
  irq_priority_enc #(.NSRC(NSRC), .IDW(IDW)) u_cand (.i_req(w_cand), .o_valid(w_cval), .o_id(w_cid));
`ifdef NESTED_IRQ_EN
  logic           w_lval, w_nval, w_nest;
  logic [IDW-1:0] w_lid, w_nid;
  logic [NSRC-1:0] w_pop;
  assign w_pop  = r_insvc & (r_insvc - NSRC'(1));
  assign w_nest = w_cval && (!w_lval || w_cid < w_lid);
  irq_priority_enc #(.NSRC(NSRC), .IDW(IDW)) u_lvl (.i_req(r_insvc), .o_valid(w_lval), .o_id(w_lid));
  irq_priority_enc #(.NSRC(NSRC), .IDW(IDW)) u_nxt (.i_req(w_pop), .o_valid(w_nval), .o_id(w_nid));
`endif
  always_comb begin
    w_state_n = r_state;
    w_vec_n   = r_vec;
    w_insvc_n = r_insvc;
    w_ack_clr = '0;
    w_intr_n  = 1'b0;
    case (r_state)
      IDLE: w_state_n = w_cval ? REQ : IDLE;
      REQ: begin
        w_state_n = (bus.INTA && w_cval) ? INSVC : (bus.INTA || !w_cval) ? IDLE : REQ;
        w_vec_n   = bus.INTA ? (w_cval ? w_cid : '0) : r_vec;
        w_insvc_n = (bus.INTA && w_cval) ? (r_insvc | w_onehot) : r_insvc;
        w_ack_clr = (bus.INTA && w_cval) ? w_onehot : '0;
      end
      INSVC: begin
`ifdef NESTED_IRQ_EN
        if (w_eoi) begin
          w_insvc_n = w_pop;
          w_vec_n   = w_nid;
          w_state_n = w_nval ? INSVC : IDLE;
        end else if (bus.INTA && r_intr && w_nest) begin
          w_insvc_n = r_insvc | w_onehot;
          w_vec_n   = w_cid;
          w_ack_clr = w_onehot;
        end else begin
          w_intr_n = w_nest;
        end
`else
        w_insvc_n = w_eoi ? (r_insvc & ~(NSRC'(1) << r_vec)) : r_insvc;
        w_state_n = w_eoi ? IDLE : INSVC;
`endif
      end
      default: w_state_n = IDLE;
    endcase
    w_intr_n = w_intr_n || w_state_n == REQ;
  end
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_s1    <= '0;
      r_s2    <= '0;
      r_s3    <= '0;
      r_vld   <= '0;
      r_pend  <= '0;
      r_mask  <= '0;
      r_insvc <= '0;
      r_state <= IDLE;
      r_intr  <= 1'b0;
      r_vec   <= '0;
    end else begin
      r_s1    <= IRQ_IN;
      r_s2    <= r_s1;
      r_s3    <= r_s2;
      r_vld   <= {r_vld[1:0], 1'b1};
      r_pend  <= (r_pend & ~(w_w1c | w_ack_clr)) | w_edge;
      r_mask  <= w_wr_mask ? DATABUS[NSRC-1:0] : r_mask;
      r_insvc <= w_insvc_n;
      r_state <= w_state_n;
      r_intr  <= w_intr_n;
      r_vec   <= w_vec_n;
    end
  end
endmodule
